// File: rtl/pe_inject_buffer.sv
// rtl/pe_inject_buffer.sv - two-VC PE injection FIFOs steering each head to the cw/ccw output arbiters
// Optional accept counters and sticky drop flag are built only when PE_INJECT_STATS_EN is defined.
module pe_inject_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int DIR_BIT    = 62,
  parameter int DEPTH      = 4
`ifdef PE_INJECT_STATS_EN
  ,
  parameter int CNT_W      = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  polarity,
  input  logic                  pesi,
  input  logic [DATA_WIDTH-1:0] pedi,
  output logic                  peri,
  output logic [1:0]            req_cw,
  output logic [1:0]            req_ccw,
  input  logic [1:0]            gnt_cw,
  input  logic [1:0]            gnt_ccw,
  output logic [DATA_WIDTH-1:0] data_out_even,
  output logic [DATA_WIDTH-1:0] data_out_odd
`ifdef PE_INJECT_STATS_EN
  ,
  output logic [CNT_W-1:0]      acc_cnt_even,
  output logic [CNT_W-1:0]      acc_cnt_odd,
  output logic                  drop_flag
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int QW = AW + 1;

  logic [1:0]            w_full;
  logic [1:0]            w_empty;
  logic [1:0]            w_push;
  logic [1:0]            w_pop;
  logic [DATA_WIDTH-1:0] w_head [2];

  // Full blocks the PE even if the same VC pops this cycle: no bypass path.
  assign peri = !w_full[polarity];

  for (genvar v = 0; v < 2; v++) begin : g_vc
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [QW-1:0]         r_cnt;

    assign w_full[v]  = (r_cnt == QW'(DEPTH));
    assign w_empty[v] = (r_cnt == '0);
    assign w_push[v]  = pesi & peri & (polarity == 1'(v));
    assign w_head[v]  = w_empty[v] ? '0 : r_mem[r_rd_ptr];

    assign req_cw[v]  = !w_empty[v] & !w_head[v][DIR_BIT];
    assign req_ccw[v] = !w_empty[v] &  w_head[v][DIR_BIT];
    assign w_pop[v]   = (gnt_cw[v] & req_cw[v]) | (gnt_ccw[v] & req_ccw[v]);

    always_ff @(posedge clk) begin
      if (w_push[v]) begin
        r_mem[r_wr_ptr] <= pedi;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_cnt    <= '0;
      end else begin
        if (w_push[v]) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop[v])  r_rd_ptr <= r_rd_ptr + AW'(1);
        case ({w_push[v], w_pop[v]})
          2'b10:   r_cnt <= r_cnt + QW'(1);
          2'b01:   r_cnt <= r_cnt - QW'(1);
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

  assign data_out_even = w_head[0];
  assign data_out_odd  = w_head[1];

`ifdef PE_INJECT_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_cnt_even <= '0;
      acc_cnt_odd  <= '0;
      drop_flag    <= 1'b0;
    end else begin
      if (w_push[0] && (acc_cnt_even != '1)) acc_cnt_even <= acc_cnt_even + CNT_W'(1);
      if (w_push[1] && (acc_cnt_odd  != '1)) acc_cnt_odd  <= acc_cnt_odd  + CNT_W'(1);
      if (pesi && !peri) drop_flag <= 1'b1;
    end
  end
`endif

endmodule
